// File: rtl/ringosc_pkg.sv
// Purpose : shared types and defaults for the ring-oscillator frequency meter.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package ringosc_pkg;

   // Measurement sequencer states.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam int DEF_CHANNELS = 4;
   localparam int DEF_CNT_W    = 16;
   localparam int DEF_GATE_W   = 16;
   localparam int DEF_SETTLE   = 8;

   // Channel-select width; never narrower than one bit.
   function automatic int calc_ch_w(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Purpose : brings one asynchronous oscillator output into clk and flags its rising edges.
// Latency : 3 cycles from d to rise (two synchroniser flops plus one history flop).
// Backpressure: none; clr holds every flop at 0 while the channel is unselected.
// Ports   : clk, rst_n (async, active low), clr (sync clear), d (async input), rise (one-cycle edge flag).
module ro_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic d,
   output logic rise
);

   // Bit 0 = first synchroniser stage, bit 1 = second, bit 2 = history.
   logic [2:0] sync_q, sync_d;

   always_comb begin
      sync_d = clr ? 3'b000 : {sync_q[1:0], d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 3'b000;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/ringosc_freq_meter.sv
// Purpose : enables one ring oscillator and counts its rising edges over a gate window.
// Latency : done arrives SETTLE+G+1 cycles after the accepting start edge; continuous period G+1.
// Backpressure: start is accepted only in IDLE with ena high; otherwise dropped, never queued.
// Ports   : ro_in/ro_en oscillator side; ch_sel, gate_cycles, cont, start request side;
//           busy, done, count, overflow result side; ena low aborts to IDLE.
module ringosc_freq_meter
   import ringosc_pkg::*;
#(
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int CNT_W    = DEF_CNT_W,
   parameter int GATE_W   = DEF_GATE_W,
   parameter int SETTLE   = DEF_SETTLE
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           ena,
   input  logic [CHANNELS-1:0]            ro_in,
   output logic [CHANNELS-1:0]            ro_en,
   input  logic [calc_ch_w(CHANNELS)-1:0] ch_sel,
   input  logic [GATE_W-1:0]              gate_cycles,
   input  logic                           cont,
   input  logic                           start,
   output logic                           busy,
   output logic                           done,
   output logic [CNT_W-1:0]               count,
   output logic                           overflow
);

   localparam int CH_W  = calc_ch_w(CHANNELS);
   localparam int SET_W = $clog2(SETTLE + 1);
   localparam int TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t              state_q, state_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic [GATE_W-1:0]   gate_q, gate_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;      // shared settle / gate down-counter
   logic [CNT_W-1:0]    edges_q, edges_d;
   logic                ovf_acc_q, ovf_acc_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                overflow_q, overflow_d;
   logic [CHANNELS-1:0] rise_vec;
   logic                rise_sel;

   // Only the latched channel runs; its enable also releases its synchroniser.
   always_comb begin
      ro_en = '0;
      if (state_q != IDLE) begin
         ro_en[ch_q] = 1'b1;
      end
   end

   assign busy = (state_q != IDLE);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_sync
      ro_edge_sync u_sync (
         .clk  (clk),
         .rst_n(rst_n),
         .clr  (~ro_en[i]),
         .d    (ro_in[i]),
         .rise (rise_vec[i])
      );
   end

   assign rise_sel = rise_vec[ch_q];

   always_comb begin
      state_d    = state_q;
      ch_d       = ch_q;
      gate_d     = gate_q;
      tmr_d      = tmr_q;
      edges_d    = edges_q;
      ovf_acc_d  = ovf_acc_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      done       = 1'b0;
      // In DONE the accumulators are shown directly so count is valid in the done cycle.
      count      = count_q;
      overflow   = overflow_q;

      if (!ena) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_d = ARM;
                  ch_d    = CH_W'(32'(ch_sel) % CHANNELS);
                  gate_d  = (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;
                  tmr_d   = TMR_W'(SETTLE - 1);
               end
            end
            ARM: begin
               if (tmr_q == '0) begin
                  state_d   = MEASURE;
                  tmr_d     = TMR_W'(gate_q) - TMR_W'(1);
                  edges_d   = '0;
                  ovf_acc_d = 1'b0;
               end else begin
                  tmr_d = tmr_q - TMR_W'(1);
               end
            end
            MEASURE: begin
               if (rise_sel) begin
                  if (edges_q == CNT_MAX) begin
                     ovf_acc_d = 1'b1;
                  end else begin
                     edges_d = edges_q + CNT_W'(1);
                  end
               end
               if (tmr_q == '0) begin
                  state_d = DONE;
               end else begin
                  tmr_d = tmr_q - TMR_W'(1);
               end
            end
            DONE: begin
               done       = 1'b1;
               count      = edges_q;
               overflow   = ovf_acc_q;
               count_d    = edges_q;
               overflow_d = ovf_acc_q;
               if (cont) begin
                  state_d   = MEASURE;
                  tmr_d     = TMR_W'(gate_q) - TMR_W'(1);
                  edges_d   = '0;
                  ovf_acc_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ch_q       <= '0;
         gate_q     <= '0;
         tmr_q      <= '0;
         edges_q    <= '0;
         ovf_acc_q  <= 1'b0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ch_q       <= ch_d;
         gate_q     <= gate_d;
         tmr_q      <= tmr_d;
         edges_q    <= edges_d;
         ovf_acc_q  <= ovf_acc_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: tb/tb_ringosc_freq_meter.sv
module tb_ringosc_freq_meter;

   localparam int S = 8;

   logic        clk = 1'b0;
   logic        rst_n, ena, cont, start;
   logic [3:0]  ro_in;
   logic [1:0]  ch_sel;
   logic [15:0] gate_cycles;

   logic [3:0]  ro_en_a, ro_en_b;
   logic        busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;
   logic [15:0] count_a;
   logic [3:0]  count_b;

   ringosc_freq_meter #(.CHANNELS(4), .CNT_W(16), .GATE_W(16), .SETTLE(S)) dut_a (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ro_in(ro_in), .ro_en(ro_en_a),
      .ch_sel(ch_sel), .gate_cycles(gate_cycles), .cont(cont), .start(start),
      .busy(busy_a), .done(done_a), .count(count_a), .overflow(ovf_a));

   // Narrow counter instance to exercise saturation.
   ringosc_freq_meter #(.CHANNELS(4), .CNT_W(4), .GATE_W(16), .SETTLE(S)) dut_b (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ro_in(ro_in), .ro_en(ro_en_b),
      .ch_sel(ch_sel), .gate_cycles(gate_cycles), .cont(cont), .start(start),
      .busy(busy_b), .done(done_b), .count(count_b), .overflow(ovf_b));

   always #5 clk = ~clk;

   // Cycle k is the interval after the k-th rising edge; hist[k] is ro_in seen at that edge.
   int         cyc = 0;
   logic [3:0] hist [0:16383];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      hist[cyc + 1] <= ro_in;
   end

   // Square-wave sources: channel i toggles every half[i] clk cycles.
   int half [4];
   int ph   [4];
   initial begin
      ro_in = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         half[i] = 5;
         ph[i]   = 0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (ph[i] + 1 >= half[i]) begin
               ph[i]    = 0;
               ro_in[i] = ~ro_in[i];
            end else begin
               ph[i] = ph[i] + 1;
            end
         end
      end
   end

   int total = 0;
   int bad   = 0;
   int last_a = 0, last_b = 0, last_ovf_b = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Rising edges of the sampled waveform that reach the counter in cycles d-g .. d-1:
   // the 2-flop synchroniser plus history flop turns a 0->1 step between samples
   // k-2 and k-1 into an edge seen in cycle k.
   function automatic int model_edges(input int ch, input int d, input int g);
      int n = 0;
      for (int k = d - g; k < d; k++) begin
         if (hist[k-1][ch] && !hist[k-2][ch]) n++;
      end
      return n;
   endfunction

   task automatic check_quiet(input string tag);
      check_eq({tag, "_busy_a"}, busy_a, 0);
      check_eq({tag, "_done_a"}, done_a, 0);
      check_eq({tag, "_ro_en_a"}, ro_en_a, 0);
      check_eq({tag, "_busy_b"}, busy_b, 0);
      check_eq({tag, "_ro_en_b"}, ro_en_b, 0);
   endtask

   task automatic check_zero(input string tag);
      check_quiet(tag);
      check_eq({tag, "_count_a"}, count_a, 0);
      check_eq({tag, "_ovf_a"}, ovf_a, 0);
      check_eq({tag, "_count_b"}, count_b, 0);
      check_eq({tag, "_ovf_b"}, ovf_b, 0);
      check_eq({tag, "_done_b"}, done_b, 0);
   endtask

   // Presents start for one cycle; t is the cycle in which start is high.
   // Returns at the negedge of the first ARM cycle (t+1).
   task automatic do_start(input int ch, input int g, input logic c, output int t);
      @(negedge clk);
      ch_sel      = 2'(ch);
      gate_cycles = 16'(g);
      cont        = c;
      start       = 1'b1;
      t           = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int d);
      d = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done_a === 1'b1) begin
            d = cyc;
            break;
         end
      end
   endtask

   task automatic check_result(input string tag, input int ch, input int g,
                               input int exp_d, input int budget);
      int d, n;
      wait_done(budget, d);
      check_eq({tag, "_done_cyc"}, d, exp_d);
      if (d >= 0) begin
         n = model_edges(ch, d, g);
         check_eq({tag, "_done_b"}, done_b, 1);
         check_eq({tag, "_count_a"}, count_a, (n > 65535) ? 65535 : n);
         check_eq({tag, "_ovf_a"}, ovf_a, 0);
         check_eq({tag, "_count_b"}, count_b, (n > 15) ? 15 : n);
         check_eq({tag, "_ovf_b"}, ovf_b, (n > 15) ? 1 : 0);
         last_a     = n;
         last_b     = (n > 15) ? 15 : n;
         last_ovf_b = (n > 15) ? 1 : 0;
      end
   endtask

   initial begin
      int t, d1, d2, gg, ch, g, seen;
      rst_n = 1'b0; ena = 1'b0; cont = 1'b0; start = 1'b0;
      ch_sel = 2'd0; gate_cycles = 16'd0;

      // Reset and idle.
      repeat (3) @(negedge clk);
      check_zero("rst");
      rst_n = 1'b1;
      @(negedge clk);
      check_zero("idle");

      // start with ena low is not accepted.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check_quiet("ena0_start");
      ena = 1'b1;

      // Channel 1, period 10, gate 100: exactly 10 rising edges in any 100-cycle window.
      half[1] = 5;
      do_start(1, 100, 1'b0, t);
      check_eq("t1_arm_ro_en", ro_en_a, 4'b0010);
      check_eq("t1_arm_busy", busy_a, 1);
      repeat (S + 10) @(negedge clk);
      check_eq("t1_meas_ro_en", ro_en_a, 4'b0010);
      check_result("t1", 1, 100, t + 1 + S + 100, 200);
      check_eq("t1_ten", count_a, 10);
      @(negedge clk);
      check_eq("t1_done_pulse", done_a, 0);
      check_eq("t1_idle_busy", busy_a, 0);
      check_eq("t1_held_count", count_a, 10);

      // Channel 0, period 4, gate 100: 25 edges, saturates the 4-bit instance.
      half[0] = 2;
      do_start(0, 100, 1'b0, t);
      check_result("sat", 0, 100, t + 1 + S + 100, 200);
      check_eq("sat_25", count_a, 25);
      check_eq("sat_b15", count_b, 15);
      check_eq("sat_ovf_b", ovf_b, 1);

      // Continuous mode, channel 2, period 20, gate 200.
      half[2] = 10;
      do_start(2, 200, 1'b1, t);
      d1 = t + 1 + S + 200;
      check_result("c1", 2, 200, d1, 400);
      check_eq("c1_ten", count_a, 10);
      check_result("c2", 2, 200, d1 + 201, 400);
      check_eq("c2_ten", count_a, 10);
      check_eq("c2_ro_en", ro_en_a, 4'b0100);
      d2 = d1 + 201;
      @(negedge clk);
      check_eq("c_meas_busy", busy_a, 1);
      cont = 1'b0;
      check_result("c3", 2, 200, d2 + 201, 400);
      @(negedge clk);
      check_eq("c_end_busy", busy_a, 0);

      // start during MEASURE with channel 3 is ignored.
      half[0] = 3;
      half[3] = 1;
      do_start(0, 60, 1'b0, t);
      repeat (S + 5) @(negedge clk);
      ch_sel = 2'd3; gate_cycles = 16'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq("ign_ro_en", ro_en_a, 4'b0001);
      check_result("ign", 0, 60, t + 1 + S + 60, 150);
      check_eq("ign_ten", count_a, 10);
      repeat (3) @(negedge clk);
      check_eq("ign_idle", busy_a, 0);

      // gate_cycles = 0 behaves as 1.
      do_start(1, 0, 1'b0, t);
      check_result("g0", 1, 1, t + S + 2, 40);

      // ena dropped mid-MEASURE.
      do_start(2, 100, 1'b0, t);
      repeat (S + 20) @(negedge clk);
      ena = 1'b0;
      @(negedge clk);
      check_eq("ena_busy", busy_a, 0);
      check_eq("ena_ro_en", ro_en_a, 0);
      seen = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (done_a === 1'b1 || done_b === 1'b1) seen++;
      end
      check_eq("ena_no_done", seen, 0);
      check_eq("ena_keep_a", count_a, last_a);
      check_eq("ena_keep_b", count_b, last_b);
      check_eq("ena_keep_ovf_b", ovf_b, last_ovf_b);
      ena = 1'b1;

      // Reset pulse mid-MEASURE after a nonzero result.
      half[3] = 4;
      do_start(3, 100, 1'b0, t);
      check_result("pre_rst", 3, 100, t + 1 + S + 100, 200);
      do_start(3, 100, 1'b0, t);
      repeat (S + 20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_zero("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (130) @(negedge clk);
      check_zero("post_rst");

      // Randomised measurements.
      for (int it = 0; it < 10; it++) begin
         for (int i = 0; i < 4; i++) half[i] = $urandom_range(1, 12);
         ch = $urandom_range(0, 3);
         g  = $urandom_range(0, 300);
         gg = (g == 0) ? 1 : g;
         do_start(ch, g, 1'b0, t);
         check_eq($sformatf("rnd%0d_ro_en", it), ro_en_a, 32'(1) << ch);
         check_result($sformatf("rnd%0d", it), ch, gg, t + 1 + S + gg, gg + S + 20);
         @(negedge clk);
         check_eq($sformatf("rnd%0d_idle", it), busy_a, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ringosc_freq_meter.md
# ringosc_freq_meter

Multi-channel ring-oscillator frequency meter for the tt_um ring-oscillator tile. Enables one of `CHANNELS` ring oscillators at a time and synchronises its divided output into `clk`. Counts its rising edges over a programmable gate window and reports the count with a done pulse. Single-shot and continuous modes. Sits between the top-level pin wrapper and the `ringosc` instances.

## Interface
- `CHANNELS`, 4: number of oscillator inputs (≥2).
- `CNT_W`, 16: result counter width.
- `GATE_W`, 16: gate-window length width.
- `SETTLE`, 8: cycles the oscillator runs before counting starts (≥3).
- `clk` in 1: system clock, the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: block enable; low aborts to IDLE.
- `ro_in` in CHANNELS: oscillator outputs, asynchronous to `clk`.
- `ro_en` out CHANNELS: one-hot oscillator enable; zero when idle.
- `ch_sel` in $clog2(CHANNELS): channel to measure, sampled on accepted `start`.
- `gate_cycles` in GATE_W: window length in `clk` cycles, sampled on accepted `start`; 0 is treated as 1.
- `cont` in 1: continuous mode, sampled every DONE cycle.
- `start` in 1: request; accepted only in IDLE with `ena`=1.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when `count` updates.
- `count` out CNT_W: last completed measurement, held until the next one completes.
- `overflow` out 1: last measurement saturated.

## Operation
- States: IDLE, ARM, MEASURE, DONE.
- **IDLE:**
  - `ro_en`=0.
  - On accepted `start`, latch `ch_sel` and `gate_cycles` and go to ARM.
  - Out-of-range `ch_sel` wraps modulo CHANNELS.
- **ARM:**
  - `ro_en[ch]`=1 and the settle counter runs.
  - After exactly SETTLE cycles, go to MEASURE.
  - The edge counter and overflow accumulator clear on MEASURE entry.
- **MEASURE:**
  - Lasts exactly the latched `gate_cycles` cycles.
  - Each cycle with a detected rising edge increments the edge counter.
  - The counter saturates at 2^CNT_W−1; any increment attempted at saturation sets the overflow accumulator.
- **DONE:** one cycle.
  - `count` and `overflow` load from the accumulators and `done`=1.
  - With `cont`=1 and `ena`=1, go to MEASURE with the same channel and gate, keeping `ro_en` asserted; otherwise go to IDLE.
- Edge detection:
  - 2-flop synchroniser, plus a third flop; rising edge = s2 & ~s3.
  - Only the selected channel's synchroniser feeds the counter.
  - Synchronisers of unselected channels are held at 0.
- `start` outside IDLE is ignored; it is not queued.
- `ena` low in any state:
  - Next state is IDLE and `ro_en` drops next cycle.
  - No `done`; `count` and `overflow` keep their previous values.
- Inputs toggling faster than `clk`/2 are undercounted. This is not detected; the oscillators must be divided down upstream.

## Timing
- Reset values:
  - state IDLE; `ro_en`=0, `busy`=0, `done`=0, `count`=0, `overflow`=0.
  - All synchronisers and internal counters are 0.
- `start` sampled at edge t gives ARM from t+1, with `busy` and `ro_en` high from t+1.
- MEASURE spans cycles t+1+SETTLE … t+SETTLE+G, where G is the latched gate length.
- DONE and `done` occur in cycle t+1+SETTLE+G; `count` is valid from that same cycle.
- Single shot: IDLE in t+2+SETTLE+G; `start` may be accepted on that edge.
- Continuous: the next window starts the cycle after DONE, giving a measurement period of G+1 cycles. The DONE cycle itself is not counted.
- Synchroniser latency is 3 cycles. Edges within the last 3 cycles before MEASURE entry may be counted; this is accepted measurement error (±1 count).
- Reset mid-operation: immediate return to reset values; no `done`.

## Structure
- Package `ringosc_pkg`:
  - state enum (IDLE, ARM, MEASURE, DONE);
  - default parameter constants;
  - `CH_W = $clog2(CHANNELS)` helper function.
- Sub-module `ro_edge_sync`:
  - one per channel, with inputs `clk`, `rst_n`, `clr`, `d`;
  - output `rise`: 3-flop synchroniser plus edge detect.
- Top of the block: FSM, settle/gate counter (shared down-counter, width max(GATE_W, $clog2(SETTLE+1))), saturating edge counter, result registers.

## Test plan
- Reset, then idle: all outputs 0; `start` with `ena`=0 gives no `busy`.
- ch 1 square wave, period 10 clk; `gate_cycles`=100, SETTLE=8: `done` 109 cycles after start, `count`=10 (±1), `overflow`=0, only `ro_en[1]` high during ARM/MEASURE.
- CNT_W=4, period 4, gate 100: `count`=15, `overflow`=1.
- `cont`=1, ch 2, period 20, gate 200: `done` pulses every 201 cycles, each `count`=10; clear `cont` and the block returns to IDLE after the next DONE.
- `start` pulsed during MEASURE with ch 3: ignored, the ongoing result is unchanged; `gate_cycles`=0 gives `done` SETTLE+2 cycles after start.
- `ena` dropped mid-MEASURE: IDLE next cycle, no `done`, previous `count` retained. Repeat with `rst_n` pulse: all outputs 0 at once.
